// File: rtl/cdc_pkg.sv
// Shared constants and helpers for the toggle-event CDC receiver.
//   clog2     : ceiling log2 used to size channel IDs
//   cdc_id_w  : channel-ID width, never narrower than one bit
//   CDC_SYNC_STAGES / CDC_CNT_W : default synchroniser depth and pending-counter width
package cdc_pkg;

    localparam int CDC_SYNC_STAGES = 2;
    localparam int CDC_CNT_W       = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int cdc_id_w(input int channels);
        return (channels <= 1) ? 1 : clog2(channels);
    endfunction

endpackage

// File: rtl/cdc_toggle_sync.sv
// One channel of toggle synchronisation into the sink clock.
//   clk       in  : sink-domain clock
//   reset_i   in  : synchronous active-high reset
//   req_tog_i in  : asynchronous request toggle from the source domain
//   evt_det_o out : one-cycle pulse per captured toggle transition
//   ack_tog_o out : last captured request level, returned to the source
module cdc_toggle_sync #(
    parameter int pSYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_i,
    input  logic req_tog_i,
    output logic evt_det_o,
    output logic ack_tog_o
);

    (* ASYNC_REG = "TRUE" *) logic [pSYNC_STAGES-1:0] sync_q;
    logic tog_q;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            sync_q <= '0;
            tog_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[pSYNC_STAGES-2:0], req_tog_i};
            tog_q  <= sync_q[pSYNC_STAGES-1];
        end
    end

    // tog_q trails the synchronised level by one cycle, so any difference
    // is exactly one new transition from the source.
    assign evt_det_o = sync_q[pSYNC_STAGES-1] ^ tog_q;
    assign ack_tog_o = tog_q;

endmodule

// File: rtl/cdc_event_sync.sv
// Multi-channel toggle-event receiver: synchronises per-channel request
// toggles, queues events as saturating pending counts and issues them one
// at a time in round-robin order on a valid/ready port.
//   clk          in  : sink-domain clock
//   reset_i      in  : synchronous active-high reset
//   req_tog_i    in  : per-channel async request toggles
//   ack_tog_o    out : per-channel ack toggles (captured request level)
//   evt_valid_o  out : event presented on evt_id_o
//   evt_ready_i  in  : sink accepts when evt_valid_o & evt_ready_i
//   evt_id_o     out : channel index of the presented event
//   ovf_o        out : sticky per-channel overflow flags
//   ovf_clr_i    in  : per-channel overflow clear pulses
module cdc_event_sync
    import cdc_pkg::*;
#(
    parameter int  pCHANNELS    = 4,
    parameter int  pSYNC_STAGES = CDC_SYNC_STAGES,
    parameter int  pCNT_W       = CDC_CNT_W,
    localparam int pID_W        = cdc_id_w(pCHANNELS)
) (
    input  logic                 clk,
    input  logic                 reset_i,
    input  logic [pCHANNELS-1:0] req_tog_i,
    output logic [pCHANNELS-1:0] ack_tog_o,
    output logic                 evt_valid_o,
    input  logic                 evt_ready_i,
    output logic [pID_W-1:0]     evt_id_o,
    output logic [pCHANNELS-1:0] ovf_o,
    input  logic [pCHANNELS-1:0] ovf_clr_i
);

    localparam logic [pCNT_W-1:0] CNT_MAX = '1;

    logic [pCHANNELS-1:0]             evt_det;
    logic [pCHANNELS-1:0][pCNT_W-1:0] cnt_q, cnt_d;
    logic [pCHANNELS-1:0]             ovf_q, ovf_d, ovf_set;
    logic [pCHANNELS-1:0]             take;
    logic [pID_W-1:0]                 rr_q, rr_d, id_q, id_d, sel;
    logic                             valid_q, valid_d, load, found;

    for (genvar c = 0; c < pCHANNELS; c++) begin : g_sync
        cdc_toggle_sync #(.pSYNC_STAGES(pSYNC_STAGES)) u_sync (
            .clk       (clk),
            .reset_i   (reset_i),
            .req_tog_i (req_tog_i[c]),
            .evt_det_o (evt_det[c]),
            .ack_tog_o (ack_tog_o[c])
        );
    end

    // Round-robin search: first nonzero counter at or after rr_q, wrapping.
    always_comb begin
        int idx;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int i = 0; i < pCHANNELS; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= pCHANNELS) idx = idx - pCHANNELS;
            if (!found && cnt_q[idx] != '0) begin
                found = 1'b1;
                sel   = pID_W'(idx);
            end
        end
    end

    // Output stage refills whenever it is empty or being drained.
    always_comb begin
        load    = ~valid_q | evt_ready_i;
        take    = '0;
        valid_d = valid_q;
        id_d    = id_q;
        rr_d    = rr_q;
        if (load) begin
            valid_d = found;
            if (found) begin
                id_d      = sel;
                take[sel] = 1'b1;
                rr_d      = (int'(sel) == pCHANNELS - 1) ? '0 : sel + pID_W'(1);
            end
        end
    end

    // A detect and a take in the same cycle cancel out. Overflow only fires
    // on a net increment into a saturated counter and beats a same-cycle clear.
    always_comb begin
        for (int c = 0; c < pCHANNELS; c++) begin
            cnt_d[c]   = cnt_q[c];
            ovf_set[c] = evt_det[c] & ~take[c] & (cnt_q[c] == CNT_MAX);
            if (evt_det[c] && !take[c] && cnt_q[c] != CNT_MAX)
                cnt_d[c] = cnt_q[c] + 1'b1;
            else if (!evt_det[c] && take[c])
                cnt_d[c] = cnt_q[c] - 1'b1;
            ovf_d[c] = ovf_set[c] ? 1'b1 : (ovf_clr_i[c] ? 1'b0 : ovf_q[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            cnt_q   <= '0;
            ovf_q   <= '0;
            rr_q    <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            valid_q <= valid_d;
        end
    end

    assign evt_valid_o = valid_q;
    assign evt_id_o    = id_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_cdc_event_sync.sv
// Bench for cdc_event_sync: vector table, directed corner sequences and a
// randomised run against an integer-count reference model.
module tb_cdc_event_sync;

    localparam int N    = 4;
    localparam int S    = 2;
    localparam int CMAX = 15;

    logic       clk = 1'b0;
    logic       rst, ready;
    logic [3:0] req, clr, ack, ovf;
    logic       valid;
    logic [1:0] id;

    int checks = 0;
    int errors = 0;

    cdc_event_sync #(.pCHANNELS(N), .pSYNC_STAGES(S), .pCNT_W(4)) dut (
        .clk         (clk),
        .reset_i     (rst),
        .req_tog_i   (req),
        .ack_tog_o   (ack),
        .evt_valid_o (valid),
        .evt_ready_i (ready),
        .evt_id_o    (id),
        .ovf_o       (ovf),
        .ovf_clr_i   (clr)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic        rdy;
        logic [10:0] exp;   // {valid, id, ack, ovf}
    } vec_t;
    vec_t vecs[$];

    function automatic void add(logic r, logic [3:0] q, logic rd, logic v, logic [1:0] i,
                                logic [3:0] a, logic [3:0] o);
        vec_t t;
        t.rst = r; t.req = q; t.rdy = rd; t.exp = {v, i, a, o};
        vecs.push_back(t);
    endfunction

    function automatic logic [10:0] outs();
        return {valid, id, ack, ovf};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; clr = '0;
        tick();
        rst = 1'b0;
    endtask

    // Toggle one channel and wait for its ack to follow.
    task automatic send(input int ch);
        req[ch] = ~req[ch];
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ack[ch] == req[ch]) return;
        end
        checks++;
        errors++;
        $display("FAIL send_ack ch%0d: ack=%0b required %0b", ch, ack[ch], req[ch]);
    endtask

    // Reference model: integer pending counts, a delay line of applied
    // request levels, and a plain round-robin search.
    int         pend [N];
    bit         mv;
    int         mid, rr;
    logic [3:0] movf;
    logic [3:0] hist [0:S+1];

    task automatic model_step(input logic r, input logic [3:0] q, input logic rd,
                              input logic [3:0] cl);
        logic [3:0] det, take;
        if (r) begin
            foreach (pend[c]) pend[c] = 0;
            foreach (hist[j]) hist[j] = '0;
            mv = 0; mid = 0; rr = 0; movf = '0;
            return;
        end
        for (int j = S + 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = q;
        det  = hist[S] ^ hist[S+1];
        take = '0;
        if (!mv || rd) begin
            mv = 0;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (rr + k) % N;
                if (!mv && pend[c] > 0) begin
                    mv = 1; mid = c; take[c] = 1'b1;
                end
            end
            if (mv) rr = (mid + 1) % N;
        end
        for (int c = 0; c < N; c++) begin
            if (det[c] && !take[c]) begin
                if (pend[c] == CMAX) movf[c] = 1'b1;
                else begin
                    pend[c]++;
                    if (cl[c]) movf[c] = 1'b0;
                end
            end else begin
                if (take[c] && !det[c]) pend[c]--;
                if (cl[c]) movf[c] = 1'b0;
            end
        end
    endtask

    initial begin
        logic [3:0] nreq, nclr;
        logic       nrst, nrdy;
        int         n, bad;
        bit         stall;

        rst = 1'b1; req = '0; ready = 1'b1; clr = '0;

        // Single event on ch2, then three simultaneous events after a reset.
        add(1, 4'h0, 1, 0, 0, 4'h0, 4'h0);
        add(0, 4'h4, 1, 0, 0, 4'h0, 4'h0);
        add(0, 4'h4, 1, 0, 0, 4'h0, 4'h0);
        add(0, 4'h4, 1, 0, 0, 4'h4, 4'h0);
        add(0, 4'h4, 1, 1, 2, 4'h4, 4'h0);
        add(0, 4'h4, 1, 0, 2, 4'h4, 4'h0);
        add(1, 4'h0, 1, 0, 0, 4'h0, 4'h0);
        add(0, 4'hB, 1, 0, 0, 4'h0, 4'h0);
        add(0, 4'hB, 1, 0, 0, 4'h0, 4'h0);
        add(0, 4'hB, 1, 0, 0, 4'hB, 4'h0);
        add(0, 4'hB, 1, 1, 0, 4'hB, 4'h0);
        add(0, 4'hB, 1, 1, 1, 4'hB, 4'h0);
        add(0, 4'hB, 1, 1, 3, 4'hB, 4'h0);
        add(0, 4'hB, 1, 0, 3, 4'hB, 4'h0);
        foreach (vecs[i]) begin
            rst = vecs[i].rst; req = vecs[i].req; ready = vecs[i].rdy;
            tick();
            chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // Saturation: 17 events on ch1 with the sink stalled.
        do_reset();
        ready = 1'b0;
        for (int k = 0; k < 17; k++) send(1);
        tick();
        chk("sat_ovf", ovf[1], 1);
        chk("sat_present", {valid, id}, {1'b1, 2'd1});
        ready = 1'b1; n = 0; bad = 0;
        for (int k = 0; k < 40; k++) begin
            if (valid) begin n++; if (id != 2'd1) bad++; end
            tick();
        end
        chk("drain_count", n, 16);
        chk("drain_id", bad, 0);

        // Overflow clear, then clear colliding with a fresh overflow.
        clr = 4'b0010; tick(); clr = '0;
        chk("ovf_clr", ovf[1], 0);
        ready = 1'b0;
        for (int k = 0; k < 16; k++) send(1);
        chk("refill_no_ovf", ovf[1], 0);
        req[1] = ~req[1];
        tick(); tick();
        clr = 4'b0010; tick(); clr = '0;
        chk("ovf_set_wins", ovf[1], 1);
        clr = 4'b0010; tick(); clr = '0;
        chk("ovf_clr_later", ovf[1], 0);

        // Presented ID held under back-pressure, then RR from held ID+1.
        do_reset();
        ready = 1'b0;
        send(2);
        tick();
        chk("hold_first", {valid, id}, {1'b1, 2'd2});
        req = req ^ 4'b1011;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("hold_stable%0d", k), {valid, id}, {1'b1, 2'd2});
        end
        ready = 1'b1;
        tick(); chk("rr_a", {valid, id}, {1'b1, 2'd3});
        tick(); chk("rr_b", {valid, id}, {1'b1, 2'd0});
        tick(); chk("rr_c", {valid, id}, {1'b1, 2'd1});
        tick(); chk("rr_done", valid, 0);

        // Reset with events pending and presented.
        do_reset();
        ready = 1'b0; req = 4'hF;
        for (int k = 0; k < 6; k++) tick();
        chk("pre_rst", {valid, id}, {1'b1, 2'd0});
        rst = 1'b1; req = '0;
        tick();
        chk("rst_outs", outs(), 0);
        rst = 1'b0; ready = 1'b1; n = 0;
        for (int k = 0; k < 10; k++) begin tick(); if (valid) n++; end
        chk("rst_no_evt", n, 0);
        rst = 1'b1; req = 4'b0100;
        tick();
        rst = 1'b0; n = 0; bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (valid) begin n++; if (id != 2'd2) bad++; end
        end
        chk("rst_held_req", n, 1);
        chk("rst_held_id", bad, 0);

        // Randomised run against the model.
        rst = 1'b1; req = '0; clr = '0; ready = 1'b1;
        model_step(1'b1, '0, 1'b1, '0);
        tick();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            chk("rand", outs(), {mv, 2'(mid), hist[S], movf});
            stall = ((cyc / 160) % 2) == 1;
            nrst  = ($urandom_range(0, 399) == 0);
            nrdy  = stall ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0);
            nreq  = req;
            nclr  = '0;
            for (int c = 0; c < N; c++) begin
                if (hist[S][c] == req[c] && $urandom_range(0, stall ? 1 : 2) == 0)
                    nreq[c] = ~req[c];
                if ($urandom_range(0, 19) == 0) nclr[c] = 1'b1;
            end
            if (nrst) nreq = '0;
            rst = nrst; req = nreq; ready = nrdy; clr = nclr;
            model_step(nrst, nreq, nrdy, nclr);
            tick();
        end
        chk("rand_final", outs(), {mv, 2'(mid), hist[S], movf});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
